// File: rtl/dmux8way16_router_pkg.sv
// ---------------------------------------------------------------------------
// dmux8way16_router_pkg
// Shared constants and helpers for the 16-bit, 8-way mux/dmux family.
//   ROUTER_WIDTH : data width of one word / one lane
//   ROUTER_LANES : number of lanes (fixed at 8)
//   ROUTER_SEL_W : width of the lane select (3 bits for 8 lanes)
//   laneSel_e    : symbolic names for lanes a..h
//   laneOffset() : bit offset of a lane inside a packed lane bus
// ---------------------------------------------------------------------------
package dmux8way16_router_pkg;

  localparam int ROUTER_WIDTH = 16;
  localparam int ROUTER_LANES = 8;
  localparam int ROUTER_SEL_W = 3;

  // Lane a is select 000, lane h is select 111.
  typedef enum logic [ROUTER_SEL_W-1:0] {
    LANE_A = 3'd0,
    LANE_B = 3'd1,
    LANE_C = 3'd2,
    LANE_D = 3'd3,
    LANE_E = 3'd4,
    LANE_F = 3'd5,
    LANE_G = 3'd6,
    LANE_H = 3'd7
  } laneSel_e;

  // Lane k lives on bits [k*width +: width] of a packed lane bus.
  function automatic int laneOffset(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/dmux8way16_router_lane.sv
// ---------------------------------------------------------------------------
// dmux_lane_reg
// One output lane of the router: a one-entry holding register plus its full
// flag, with a valid/ready handshake toward the consumer.
// Ports:
//   clk        : rising-edge clock
//   rst_n      : synchronous active-low reset (clears data and full)
//   wr_en      : load wr_data this cycle (only raised when can_accept is 1)
//   wr_data    : word to load
//   rd_ready   : consumer takes the held word this cycle
//   data       : held word (kept after drain until overwritten)
//   valid      : lane holds an undelivered word
//   can_accept : lane is empty or is being drained this cycle
// ---------------------------------------------------------------------------
module dmux_lane_reg
  import dmux8way16_router_pkg::*;
#(
  parameter int WIDTH = ROUTER_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             can_accept
);

  logic [WIDTH-1:0] r_data;
  logic             r_full;

  // A drain and a refill may happen on the same edge, so the lane can take a
  // new word whenever the current one is leaving. This keeps one word per
  // cycle flowing through a lane whose consumer is always ready.
  always_comb begin
    can_accept = !r_full || rd_ready;
  end

  // Write wins over drain: a simultaneous drain+write leaves the lane full
  // with the new word. A drain alone only drops the flag, the data register
  // keeps the last word so consumers must qualify with valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data <= '0;
      r_full <= 1'b0;
    end else if (wr_en) begin
      r_data <= wr_data;
      r_full <= 1'b1;
    end else if (r_full && rd_ready) begin
      r_full <= 1'b0;
    end
  end

  assign data  = r_data;
  assign valid = r_full;

endmodule

// File: rtl/dmux8way16_router.sv
// ---------------------------------------------------------------------------
// dmux8way16_router
// Routes one 16-bit word per handshake from a single producer to one of
// eight independently handshaked output lanes, chosen by a 3-bit select.
// Each lane buffers one word, so a stalled consumer only blocks words that
// are aimed at its own lane.
// Ports:
//   clk          : rising-edge clock
//   rst_n        : synchronous active-low reset
//   in_data      : word to route
//   in_sel       : destination lane (000 = a ... 111 = h)
//   in_valid     : producer offers a word
//   in_ready     : router accepts the offered word this cycle
//   out_data     : lane k data on bits [16k+15:16k]
//   out_valid    : bit k set while lane k holds an undelivered word
//   out_ready    : bit k set when consumer k takes its word
//   routed_count : words accepted since reset (wraps at 16 bits)
// ---------------------------------------------------------------------------
module dmux8way16_router
  import dmux8way16_router_pkg::*;
#(
  parameter int WIDTH = ROUTER_WIDTH,
  parameter int LANES = ROUTER_LANES
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [WIDTH-1:0]        in_data,
  input  logic [ROUTER_SEL_W-1:0] in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH*LANES-1:0]  out_data,
  output logic [LANES-1:0]        out_valid,
  input  logic [LANES-1:0]        out_ready,
  output logic [15:0]             routed_count
);

  logic [LANES-1:0] w_canAccept;
  logic [LANES-1:0] w_wrEn;
  logic             w_accept;
  logic [15:0]      r_routedCount;

  // in_ready only looks at the selected lane, never at in_valid, so the
  // producer may use it to decide whether to present a word at all.
  always_comb begin
    in_ready = w_canAccept[in_sel];
    w_accept = in_valid && in_ready;
  end

  // One-hot write enable: at most one lane is loaded per cycle. When no word
  // is accepted, in_sel and in_data are ignored entirely.
  always_comb begin
    w_wrEn = '0;
    if (w_accept) begin
      w_wrEn[in_sel] = 1'b1;
    end
  end

  // Eight identical lanes; all of them see in_data, only the enabled one
  // captures it, so out_data is always a registered value.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    dmux_lane_reg #(
      .WIDTH(WIDTH)
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (w_wrEn[k]),
      .wr_data   (in_data),
      .rd_ready  (out_ready[k]),
      .data      (out_data[laneOffset(k, WIDTH) +: WIDTH]),
      .valid     (out_valid[k]),
      .can_accept(w_canAccept[k])
    );
  end

  // Accepted-word counter; plain modular increment, it simply rolls over
  // from 16'hFFFF to 16'h0000.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_routedCount <= '0;
    end else if (w_accept) begin
      r_routedCount <= r_routedCount + 16'd1;
    end
  end

  assign routed_count = r_routedCount;

endmodule

// File: tb/tb_dmux8way16_router.sv
// ---------------------------------------------------------------------------
// tb_dmux8way16_router
// Self-checking bench for dmux8way16_router. A negedge monitor keeps one
// queue per lane as a scoreboard: accepted words are pushed when driven and
// popped/compared when the lane delivers them. Scenario tasks add directed
// checks of their own.
// ---------------------------------------------------------------------------
module tb_dmux8way16_router;

  localparam int W = 16;
  localparam int L = 8;

  logic            clk;
  logic            rst_n;
  logic [W-1:0]    in_data;
  logic [2:0]      in_sel;
  logic            in_valid;
  logic            in_ready;
  logic [W*L-1:0]  out_data;
  logic [L-1:0]    out_valid;
  logic [L-1:0]    out_ready;
  logic [15:0]     routed_count;

  int errors = 0;
  int checks = 0;

  logic [15:0] sbQ [L][$];
  logic [15:0] expCount = 16'd0;
  bit          monReady = 1'b0;

  dmux8way16_router dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_sel      (in_sel),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .routed_count(routed_count)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Scoreboard monitor. At each falling edge the inputs for the coming rising
  // edge are stable: first compare the DUT state against the model, then
  // advance the model by what that rising edge will do.
  always @(negedge clk) begin
    logic [L-1:0] expValid;
    logic         expReady;
    for (int k = 0; k < L; k++) expValid[k] = (sbQ[k].size() != 0);
    expReady = !expValid[in_sel] || out_ready[in_sel];
    if (monReady) begin
      checks++;
      if (out_valid !== expValid) begin
        errors++;
        $display("[TB] FAIL mon_out_valid t=%0t got=%b exp=%b", $time, out_valid, expValid);
      end
      checks++;
      if (routed_count !== expCount) begin
        errors++;
        $display("[TB] FAIL mon_count t=%0t got=%h exp=%h", $time, routed_count, expCount);
      end
      checks++;
      if (in_ready !== expReady) begin
        errors++;
        $display("[TB] FAIL mon_in_ready t=%0t sel=%0d got=%b exp=%b", $time, in_sel, in_ready, expReady);
      end
      for (int k = 0; k < L; k++) begin
        if (sbQ[k].size() != 0) begin
          checks++;
          if (out_data[k*W +: W] !== sbQ[k][0]) begin
            errors++;
            $display("[TB] FAIL mon_lane_data t=%0t lane=%0d got=%h exp=%h", $time, k, out_data[k*W +: W], sbQ[k][0]);
          end
        end
      end
    end
    if (!rst_n) begin
      for (int k = 0; k < L; k++) sbQ[k].delete();
      expCount = 16'd0;
      monReady = 1'b1;
    end else begin
      for (int k = 0; k < L; k++) begin
        if (expValid[k] && out_ready[k]) void'(sbQ[k].pop_front());
      end
      if (in_valid && expReady) begin
        sbQ[in_sel].push_back(in_data);
        expCount = expCount + 16'd1;
      end
    end
  end

  // Move to 2 time units after the next rising edge, where inputs are driven.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_sel    = 3'd3;
    in_data   = 16'hAAAA;
    out_ready = '0;
    repeat (2) tick();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_valid got=%b exp=%b", out_valid, 8'h00);
    end
    checks++;
    if (out_data !== '0) begin
      errors++;
      $display("[TB] FAIL reset_data got=%h exp=0", out_data);
    end
    checks++;
    if (routed_count !== 16'd0) begin
      errors++;
      $display("[TB] FAIL reset_count got=%h exp=0", routed_count);
    end
    tick();
    checks++;
    if (out_valid !== 8'h00 || routed_count !== 16'd0) begin
      errors++;
      $display("[TB] FAIL reset_no_capture valid=%b count=%h exp valid=00 count=0", out_valid, routed_count);
    end
  endtask

  task automatic test_single_route();
    in_sel   = 3'b011;
    in_data  = 16'h4567;
    in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_ready got=%b exp=1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 8'b0000_1000) begin
      errors++;
      $display("[TB] FAIL single_valid got=%b exp=00001000", out_valid);
    end
    checks++;
    if (out_data[3*W +: W] !== 16'h4567) begin
      errors++;
      $display("[TB] FAIL single_data got=%h exp=4567", out_data[3*W +: W]);
    end
    checks++;
    if (routed_count !== 16'd1) begin
      errors++;
      $display("[TB] FAIL single_count got=%h exp=1", routed_count);
    end
    checks++;
    if ((out_data & ~{{(4*W){1'b0}}, 16'hFFFF, {(3*W){1'b0}}}) !== '0) begin
      errors++;
      $display("[TB] FAIL single_other_lanes got=%h exp=0 outside lane 3", out_data);
    end
  endtask

  task automatic test_sweep();
    logic [15:0] vals [L];
    vals = '{16'h1234, 16'h2345, 16'h3456, 16'h4567,
             16'h5678, 16'h6789, 16'h789A, 16'h89AB};
    out_ready = 8'hFF;
    tick();
    out_ready = 8'h00;
    for (int k = 0; k < L; k++) begin
      in_sel   = k[2:0];
      in_data  = vals[k];
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 8'hFF) begin
      errors++;
      $display("[TB] FAIL sweep_valid got=%b exp=11111111", out_valid);
    end
    for (int k = 0; k < L; k++) begin
      checks++;
      if (out_data[k*W +: W] !== vals[k]) begin
        errors++;
        $display("[TB] FAIL sweep_lane%0d got=%h exp=%h", k, out_data[k*W +: W], vals[k]);
      end
    end
    checks++;
    if (routed_count !== 16'd9) begin
      errors++;
      $display("[TB] FAIL sweep_count got=%h exp=9", routed_count);
    end
    for (int k = 0; k < L; k++) begin
      in_sel = k[2:0];
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL sweep_ready_sel%0d got=%b exp=0", k, in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    in_sel   = 3'b101;
    in_data  = 16'hBEEF;
    in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_stalled_ready got=%b exp=0", in_ready);
    end
    tick();
    checks++;
    if (out_data[5*W +: W] !== 16'h6789 || out_valid[5] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_hold got=%h/%b exp=6789/1", out_data[5*W +: W], out_valid[5]);
    end
    out_ready[5] = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_release_ready got=%b exp=1", in_ready);
    end
    tick();
    in_valid  = 1'b0;
    out_ready = '0;
    checks++;
    if (out_data[5*W +: W] !== 16'hBEEF || out_valid[5] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_refill got=%h/%b exp=beef/1", out_data[5*W +: W], out_valid[5]);
    end
  endtask

  task automatic test_independence();
    out_ready = 8'b0100_0000;
    tick();
    out_ready = '0;
    in_sel    = 3'b110;
    in_data   = 16'h6666;
    in_valid  = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL indep_ready got=%b exp=1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid[6] !== 1'b1 || out_data[6*W +: W] !== 16'h6666) begin
      errors++;
      $display("[TB] FAIL indep_lane6 got=%b/%h exp=1/6666", out_valid[6], out_data[6*W +: W]);
    end
    checks++;
    if (out_valid[2] !== 1'b1 || out_data[2*W +: W] !== 16'h3456) begin
      errors++;
      $display("[TB] FAIL indep_lane2 got=%b/%h exp=1/3456", out_valid[2], out_data[2*W +: W]);
    end
  endtask

  task automatic test_counter_wrap();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    tick();
    rst_n     = 1'b1;
    out_ready = 8'hFF;
    for (int i = 0; i < 65536; i++) begin
      in_sel   = i[2:0];
      in_data  = 16'($urandom);
      in_valid = 1'b1;
      if (i == 65535) begin
        checks++;
        if (routed_count !== 16'hFFFF) begin
          errors++;
          $display("[TB] FAIL wrap_ffff got=%h exp=ffff", routed_count);
        end
      end
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (routed_count !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL wrap_zero got=%h exp=0", routed_count);
    end
    tick();
    out_ready = '0;
    for (int k = 0; k < L; k++) begin
      in_sel   = k[2:0];
      in_data  = 16'hC000 | 16'(k);
      in_valid = 1'b1;
      tick();
    end
    checks++;
    if (out_valid !== 8'hFF || routed_count !== 16'd8) begin
      errors++;
      $display("[TB] FAIL wrap_fill got=%b/%h exp=ff/8", out_valid, routed_count);
    end
    rst_n  = 1'b0;
    in_sel = 3'd0;
    tick();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 8'h00 || routed_count !== 16'd0 || out_data !== '0) begin
      errors++;
      $display("[TB] FAIL midop_reset got=%b/%h/%h exp=00/0/0", out_valid, routed_count, out_data);
    end
    repeat (2) tick();
  endtask

  initial begin
    test_reset();
    test_single_route();
    test_sweep();
    test_backpressure();
    test_independence();
    test_counter_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
